serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (SHALL be >= 2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a subtraction; SHALL be honoured only when busy=0.
REQ-005 a  input  WIDTH  minuend; SHALL be captured on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; SHALL be captured on the accepted start edge.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 diff_bit  output  1  serial difference bit, LSB first.
REQ-009 diff_valid  output  1  high for exactly the cycles in which diff_bit carries a result bit.
REQ-010 diff  output  WIDTH  parallel difference (a - b) mod 2^WIDTH, registered.
REQ-011 borrow  output  1  final borrow-out; 1 iff a < b (unsigned).
REQ-012 done  output  1  single-cycle completion pulse.

Function
REQ-013 Control FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-014 Datapath SHALL be a Mealy borrow machine with two states, BR0 (no borrow) and BR1 (borrow pending); it SHALL enter BR0 on every accepted start.
REQ-015 IDLE with start=1 at edge E0: capture a and b into shift registers, clear bit counter and diff, enter BR0 and RUN.
REQ-016 IDLE with start=0: hold all state; diff and borrow keep their last values.
REQ-017 RUN, edge Ei (i=1..WIDTH), take ai/bi as the current shift-register LSBs and br as the borrow state: diff_bit <= ai ^ bi ^ br.
REQ-018 Same edge: next borrow state <= (~ai & bi) | (~(ai ^ bi) & br); both shift registers shift right by one; counter increments.
REQ-019 Same edge: result bit SHALL be written into diff bit position i-1; diff_valid <= 1.
REQ-020 Borrow transitions: BR0->BR1 only when ai=0, bi=1; BR1->BR0 only when ai=1, bi=0; otherwise hold.
REQ-021 At edge EWIDTH: borrow <= next borrow state, done <= 1, state <= IDLE; busy SHALL read 0 in that same cycle.
REQ-022 Latency: result bit k SHALL be visible in the cycle after edge E(k+1); done and final diff/borrow SHALL be visible in the cycle after edge EWIDTH, WIDTH cycles after the cycle following E0.
REQ-023 diff_valid SHALL be 0 in every cycle other than the WIDTH cycles after E1..EWIDTH.
REQ-024 done SHALL be 0 in every cycle other than the single cycle after EWIDTH.
REQ-025 diff_bit SHALL hold its last value when diff_valid=0.
REQ-026 start while busy=1 SHALL be ignored; a and b SHALL not be re-captured.
REQ-027 Back-to-back operation: start asserted in the done cycle SHALL be accepted, so busy is low for exactly one cycle between operations.
REQ-028 borrow SHALL update only at EWIDTH and not while a subtraction is in progress; diff SHALL be cleared at E0 and built bit by bit.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, BR0, counter=0, and all outputs to 0 (busy, diff_bit, diff_valid, diff, borrow, done).
REQ-030 reset SHALL take priority over start and over any in-progress RUN; an aborted operation SHALL produce no done pulse.
REQ-031 start asserted together with reset SHALL be ignored; the first start after reset deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-032 Scenario: a=0x5A, b=0x23, start pulse -> diff_bit sequence LSB first 1,1,1,0,1,1,0,0, then done=1, diff=0x37, borrow=0.
REQ-033 Scenario: a=0x10, b=0x20 -> diff=0xF0, borrow=1; a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-034 Scenario: a=b=0x7F -> diff=0x00, borrow=0, and the borrow state stays BR0 throughout.
REQ-035 Scenario: start held high continuously, a=0x05, b=0x03 -> operations repeat back-to-back, each returning diff=0x02, with busy low exactly one cycle between them; a change to a or b mid-operation does not affect the result in progress.
REQ-036 Scenario: reset asserted after 4 bits -> all outputs 0 on the next cycle, no done pulse; a new start with a=0x01, b=0x02 -> diff=0xFF, borrow=1.
REQ-037 Checks in every scenario: diff_valid asserted exactly 8 cycles, done exactly 1 cycle, and the serial bits reassemble to diff.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The master side issues operands; the slave side returns results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             diff_bit;
    logic             diff_valid;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             done;

    modport master (
        output start, a, b,
        input  busy, diff_bit, diff_valid, diff, borrow, done
    );

    modport slave (
        input  start, a, b,
        output busy, diff_bit, diff_valid, diff, borrow, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Borrow is carried by a two-state Mealy machine between bits.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic { IDLE, RUN } state_t;
    typedef enum logic { BR0, BR1 } br_t;

    state_t           state;
    br_t              br;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             dbit_q;
    logic             valid_q;
    logic             borrow_q;
    logic             done_q;

    logic ai;
    logic bi;
    logic bin;
    logic dbit;
    logic bout;

    // Full-subtractor cell on the current operand LSBs and borrow state.
    always_comb begin
        ai   = sa[0];
        bi   = sb[0];
        bin  = (br == BR1);
        dbit = ai ^ bi ^ bin;
        bout = (~ai & bi) | (~(ai ^ bi) & bin);
    end

    // Control FSM, borrow machine and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            br       <= BR0;
            sa       <= '0;
            sb       <= '0;
            cnt      <= '0;
            diff_q   <= '0;
            dbit_q   <= 1'b0;
            valid_q  <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        cnt    <= '0;
                        diff_q <= '0;
                        br     <= BR0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    dbit_q      <= dbit;
                    valid_q     <= 1'b1;
                    diff_q[cnt] <= dbit;
                    br          <= bout ? BR1 : BR0;
                    sa          <= {1'b0, sa[WIDTH-1:1]};
                    sb          <= {1'b0, sb[WIDTH-1:1]};
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow_q <= bout;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.diff_bit   = dbit_q;
    assign bus.diff_valid = valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow     = borrow_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
// Stimulus pushes expected results; a monitor pops and compares.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       br;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   bus.busy,       0);
        chk({tag, "_bit"},    bus.diff_bit,   0);
        chk({tag, "_valid"},  bus.diff_valid, 0);
        chk({tag, "_diff"},   bus.diff,       0);
        chk({tag, "_borrow"}, bus.borrow,     0);
        chk({tag, "_done"},   bus.done,       0);
    endtask

    // Monitor: flush on reset edges, compare outputs on falling edges.
    initial begin : mon
        logic [7:0] acc;
        int         nv;
        logic       pdone;
        exp_t       e;
        acc   = '0;
        nv    = 0;
        pdone = 1'b0;
        forever begin
            @(clk);
            if (clk) begin
                if (reset) begin
                    if (q.size() > 0) void'(q.pop_front());
                    nv  = 0;
                    acc = '0;
                end
            end else begin
                if (bus.diff_valid) begin
                    if (q.size() == 0) begin
                        fail("valid_without_op");
                    end else if (nv < 8) begin
                        acc[nv] = bus.diff_bit;
                        chk("serial_bit", bus.diff_bit, q[0].d[nv]);
                    end
                    nv++;
                end
                if (bus.done) begin
                    chk("done_single", pdone, 0);
                    if (q.size() == 0) begin
                        fail("done_without_op");
                    end else begin
                        e = q.pop_front();
                        chk("diff",        bus.diff,   e.d);
                        chk("borrow",      bus.borrow, e.br);
                        chk("reassembled", acc,        e.d);
                        chk("valid_count", nv,         8);
                        chk("busy_at_done", bus.busy,  0);
                    end
                    nv  = 0;
                    acc = '0;
                end
                pdone = bus.done;
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic [7:0] ed, input logic eb,
                          input bit poke);
        int n;
        bit seen;
        q.push_back('{ed, eb});
        @(posedge clk);
        #1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n    = 0;
        seen = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_start", bus.busy, 1);
            if (poke && n == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h00;
            end
            if (poke && n == 4) bus.start = 1'b0;
            if (bus.done) seen = 1;
        end
        if (seen) chk("done_latency", n, 9);
        else fail("done_timeout");
    endtask

    task automatic run_b2b();
        int n;
        int nd;
        bit gap;
        repeat (3) q.push_back('{8'h02, 1'b0});
        @(posedge clk);
        #1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.start = 1'b1;
        n   = 0;
        nd  = 0;
        gap = 0;
        while (n < 60 && nd < 3) begin
            @(negedge clk);
            n++;
            if (gap) begin
                chk("b2b_gap_busy", bus.busy, 1);
                gap = 0;
            end
            if (n % 9 == 4) begin
                bus.a = 8'hFF;
                bus.b = 8'h00;
            end
            if (n % 9 == 6) begin
                bus.a = 8'h05;
                bus.b = 8'h03;
            end
            if (bus.done) begin
                nd++;
                if (nd == 3) bus.start = 1'b0;
                else gap = 1;
            end
        end
        if (nd != 3) fail("b2b_timeout");
    endtask

    task automatic run_abort();
        int n;
        int nv;
        q.push_back('{8'h37, 1'b0});
        @(posedge clk);
        #1;
        bus.a     = 8'h5A;
        bus.b     = 8'h23;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n  = 0;
        nv = 0;
        while (n < 30 && nv < 4) begin
            @(negedge clk);
            n++;
            if (bus.diff_valid) nv++;
        end
        if (nv != 4) fail("abort_bits_timeout");
        #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        repeat (4) @(negedge clk);
        chk("abort_stays_idle", bus.busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_diff",     bus.diff,       8'hF0);
        chk("hold_borrow",   bus.borrow,     1);
        chk("hold_bit",      bus.diff_bit,   1);
        chk("hold_valid",    bus.diff_valid, 0);
        chk("hold_busy",     bus.busy,       0);
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0);
        run_b2b();
        run_abort();
        run_op(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
